// File: rtl/mc_result_bypass_source_pkg.sv
// Shared definitions for the multi-cycle result bypass source: state
// encodings, default widths and the destination record held per op.
package mc_result_bypass_source_pkg;

  localparam int REGSZ_DEF    = 64;
  localparam int MAX_WAIT_DEF = 63;

  localparam logic [1:0] MCB_IDLE = 2'd0;
  localparam logic [1:0] MCB_BUSY = 2'd1;
  localparam logic [1:0] MCB_DONE = 2'd2;

  typedef struct packed {
    logic       en0;
    logic [4:0] reg0;
    logic       en1;
    logic [4:0] reg1;
  } dest_t;

  // Port 1 wins architecturally when both ports name the same GPR.
  function automatic logic portsAlias(input dest_t d);
    return d.en0 && d.en1 && (d.reg0 == d.reg1);
  endfunction

endpackage

// File: rtl/mc_result_bypass_source.sv
// Producer end of the GPR bypass/ownership interface for multi-cycle ops:
// holds one op, advertises ownership while pending, forwards port 0 when done.
module mc_result_bypass_source
  import mc_result_bypass_source_pkg::*;
#(
  parameter int REGSZ    = REGSZ_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_gpr0_en,
  input  logic [4:0]       in_gpr0_reg,
  input  logic             in_gpr1_en,
  input  logic [4:0]       in_gpr1_reg,
  input  logic             annul,
  input  logic             res_valid,
  input  logic [REGSZ-1:0] res_value0,
  input  logic [REGSZ-1:0] res_value1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gpr0_en,
  output logic [4:0]       out_gpr0_reg,
  output logic             out_gpr1_en,
  output logic [4:0]       out_gpr1_reg,
  output logic [REGSZ-1:0] out_value0,
  output logic [REGSZ-1:0] out_value1,
  output logic [REGSZ-1:0] bypass,
  output logic [4:0]       bypass_reg,
  output logic             bypass_valid,
  output logic             writes_gpr0,
  output logic [4:0]       writes_gpr0_reg,
  output logic             writes_gpr1,
  output logic [4:0]       writes_gpr1_reg,
  output logic             timeout
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [1:0]       state_q, state_d;
  dest_t            dest_q, dest_d;
  logic [REGSZ-1:0] val0_q, val0_d;
  logic [REGSZ-1:0] val1_q, val1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             accept;
  dest_t            inDest;

  assign inDest   = '{en0: in_gpr0_en, reg0: in_gpr0_reg, en1: in_gpr1_en, reg1: in_gpr1_reg};
  assign in_ready = (state_q == MCB_IDLE) || ((state_q == MCB_DONE) && out_ready);
  assign accept   = in_valid && in_ready && !annul;

  // annul overrides every transition and discards any result arriving with it.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    val0_d    = val0_q;
    val1_d    = val1_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (annul) begin
      state_d = MCB_IDLE;
    end else begin
      case (state_q)
        MCB_IDLE: begin
          if (accept) begin
            state_d = MCB_BUSY;
            dest_d  = inDest;
            cnt_d   = '0;
          end
        end
        MCB_BUSY: begin
          if (res_valid) begin
            state_d = MCB_DONE;
            val0_d  = res_value0;
            val1_d  = res_value1;
          end else begin
            if (cnt_q != WAIT_LIMIT) cnt_d = cnt_q + CW'(1);
            if (cnt_q >= WAIT_LIMIT - CW'(1)) timeout_d = 1'b1;
          end
        end
        MCB_DONE: begin
          if (out_ready) begin
            if (accept) begin
              state_d = MCB_BUSY;
              dest_d  = inDest;
              cnt_d   = '0;
            end else begin
              state_d = MCB_IDLE;
            end
          end
        end
        default: state_d = MCB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MCB_IDLE;
      dest_q    <= '0;
      val0_q    <= '0;
      val1_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      val0_q    <= val0_d;
      val1_q    <= val1_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_valid       = (state_q == MCB_DONE);
  assign out_gpr0_en     = dest_q.en0;
  assign out_gpr0_reg    = dest_q.reg0;
  assign out_gpr1_en     = dest_q.en1;
  assign out_gpr1_reg    = dest_q.reg1;
  assign out_value0      = val0_q;
  assign out_value1      = val1_q;
  assign writes_gpr0     = (state_q != MCB_IDLE) && dest_q.en0;
  assign writes_gpr0_reg = dest_q.reg0;
  assign writes_gpr1     = (state_q != MCB_IDLE) && dest_q.en1;
  assign writes_gpr1_reg = dest_q.reg1;
  assign bypass          = val0_q;
  assign bypass_reg      = dest_q.reg0;
  assign bypass_valid    = (state_q == MCB_DONE) && dest_q.en0 && !portsAlias(dest_q);
  assign timeout         = timeout_q;

endmodule

// File: doc/mc_result_bypass_source.md
Name: mc_result_bypass_source

Overview:
- Producer end of the GPR bypass/ownership interface consumed by decode's bypass logic.
- Sits after EX for multi-cycle ops (multiply/divide):
  - holds one in-flight op;
  - advertises register ownership while the result is pending;
  - drives a valid forwarded value once the unit returns the result;
  - hands the op to MEM with a valid/ready handshake.

Parameters:
- REGSZ, 64, GPR width (matches `REGSZ in arch_defs.vh).
- MAX_WAIT, 63, cycles allowed in BUSY before a fatal timeout flag is raised.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX issues an op this cycle.
- in_ready  out  1  block can accept the op.
- in_gpr0_en  in  1  op writes destination port 0.
- in_gpr0_reg  in  5  port-0 GPR name.
- in_gpr1_en  in  1  op writes destination port 1.
- in_gpr1_reg  in  5  port-1 GPR name.
- annul  in  1  pipeline flush; kills the held op.
- res_valid  in  1  multi-cycle unit presents its result.
- res_value0  in  REGSZ  result for port 0.
- res_value1  in  REGSZ  result for port 1.
- out_valid  out  1  op complete, offered to MEM.
- out_ready  in  1  MEM accepts this cycle.
- out_gpr0_en, out_gpr0_reg, out_gpr1_en, out_gpr1_reg  out  1/5/1/5  held destinations.
- out_value0, out_value1  out  REGSZ  held results.
- bypass  out  REGSZ  forwarded value (port 0 only).
- bypass_reg  out  5  register being forwarded.
- bypass_valid  out  1  bypass is usable.
- writes_gpr0, writes_gpr0_reg, writes_gpr1, writes_gpr1_reg  out  1/5/1/5  ownership, including while pending.
- timeout  out  1  sticky; set when MAX_WAIT is exceeded.

Behaviour:
- States:
  - IDLE: empty.
  - BUSY: op held, result pending.
  - DONE: result held, out_valid=1.
- Reset (async, reset=0): state=IDLE, wait counter=0, timeout=0, all outputs 0 (values and reg names 0).
- in_ready = (IDLE) || (DONE && out_ready). Acceptance is in_valid && in_ready && !annul.
- IDLE + accept -> BUSY. Latch destinations and clear the wait counter.
- BUSY + res_valid -> DONE. Latch res_value0/1.
  - res_valid in the same cycle as acceptance is ignored; the result is sampled earliest the cycle after acceptance.
- BUSY without res_valid: increment the wait counter (saturating, width clog2(MAX_WAIT+1)). Reaching MAX_WAIT sets timeout, which is sticky until reset. State stays BUSY.
- DONE + out_ready:
  - with accept -> BUSY with the new op (back-to-back, no bubble);
  - otherwise -> IDLE.
- DONE without out_ready: hold all fields (MEM stall).
- annul has priority over every transition. Next state is IDLE and any in_valid that cycle is dropped. A res_valid arriving during annul is discarded.
- Ownership: writes_gprN = state!=IDLE && out_gprN_en; writes_gprN_reg = out_gprN_reg. All are registered, so there is no combinational path from in_*.
- bypass_valid = (state==DONE) && out_gpr0_en; bypass=out_value0; bypass_reg=out_gpr0_reg. bypass_valid is never 1 in BUSY, which forces decode to stall on ownership.
- Port-1 results are not forwarded. writes_gpr1 still asserts, so decode sees ownership without a bypass.
- If both ports name the same GPR, port 1 is the architectural winner. In that case bypass_valid is forced 0 so a stale port-0 value cannot forward.
- out_valid = state==DONE. Outputs are registered state decodes and have no dependency on out_ready.

Decomposition:
- State encoding localparams (MCB_IDLE/BUSY/DONE) go in a shared mc_defs.vh beside decode_signals.vh. REGSZ comes from arch_defs.vh.
- Single module. No sub-module is warranted; the wait counter is inline.

Test Plan:
1. Reset then accept op (gpr0 r5) -> writes_gpr0=1/reg=5 next cycle, bypass_valid=0. res_valid with value 0x1234 -> next cycle bypass_valid=1, bypass=0x1234, bypass_reg=5, out_valid=1.
2. DONE with out_ready=1 plus in_valid (r7) the same cycle -> next cycle BUSY, writes_gpr0_reg=7, bypass_valid=0, no idle bubble.
3. DONE with out_ready=0 for 4 cycles -> out_valid/bypass held stable (0x1234, r5). Then out_ready=1 with no new op -> IDLE, writes_gpr0=0.
4. annul asserted in BUSY with res_valid=1 the same cycle -> IDLE next cycle, bypass_valid=0, out_valid=0, result discarded. annul with in_valid=1 -> op not accepted.
5. Op writing r3 on both ports, result arrives -> bypass_valid=0, writes_gpr0=writes_gpr1=1, out_valid=1.
6. MAX_WAIT=4, hold BUSY with no res_valid -> timeout=1 at the 4th cycle and stays 1 after completion. Asserting reset mid-BUSY -> immediate IDLE, timeout=0.
